add_arb_seq: RTL and testbench
==============================

ADD_ARB_SEQ -- requirements
Module: add_arb_seq

Interface
REQ-001 Parameter W, default 16, operand/sum width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 req1_valid, req1_ready, req1_a, req1_b  same directions, widths and meaning for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer takes result.
REQ-010 rsp_sum  output  W  (a+b) mod 2^W.
REQ-011 rsp_carry  output  1  carry out of the MSB.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL share one 4-bit nibble adder (a, b, carry-in -> 4-bit sum, carry-out) between both requesters and compute W-bit sums nibble-serially, LSB nibble first.
REQ-015 FSM states: IDLE, CALC, DONE; IDLE->CALC on accept; CALC->DONE after the last nibble edge; DONE->IDLE on rsp_valid&rsp_ready.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester; it is a combinational function of state, valids and last_grant.
REQ-017 Arbitration: if exactly one valid, grant it; if both valid, grant the requester not recorded in last_grant; last_grant updates on every accept.
REQ-018 On accept edge E0: latch both operands and the requester id, clear the carry register and the nibble counter.
REQ-019 At edge E0+k+1 (k = 0..W/4-1) nibble k of the sum and the carry SHALL be registered; the carry-in of nibble 0 is 0.
REQ-020 State SHALL be DONE after edge E0+W/4; rsp_valid is high from that cycle (W/4 cycles accept-to-valid latency).
REQ-021 While rsp_valid is high and rsp_ready is low, rsp_sum, rsp_carry and rsp_id SHALL hold stable and no requester is accepted.
REQ-022 Requester valid deasserting while not granted SHALL have no effect; operands SHALL not be re-sampled after accept.
REQ-023 Peak throughput: one result per W/4+2 cycles with rsp_ready held high.
REQ-024 rsp_sum/rsp_carry SHALL be the registered result and retain their last value while in IDLE and CALC; only rsp_valid qualifies them.

Reset
REQ-025 rst asserted SHALL force immediately, without a clock edge: state IDLE, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_id 0, busy 0, nibble counter 0, carry 0, last_grant 1 (requester 0 wins the first tie).
REQ-026 Reset during CALC or DONE SHALL discard the operation in flight; no response for it is produced.
REQ-027 After rst deasserts, the first rising edge SHALL already be able to accept a request.

Structure
REQ-028 A shared package add_seq_pkg SHALL hold the FSM state enum, NIB_W = 4 and the default W.
REQ-029 The nibble adder SHALL be a separate combinational sub-module add_4_slice (ports a[3:0], b[3:0], cin, sum[3:0], cout) instantiated exactly once.

Verification
REQ-030 req0 only, a=0x1234, b=0x4321 -> rsp_sum=0x5555, rsp_carry=0, rsp_id=0, rsp_valid 4 cycles after accept edge.
REQ-031 req1 only, a=0xFFFF, b=0x0001 -> rsp_sum=0x0000, rsp_carry=1, rsp_id=1 (carry ripples through all nibbles).
REQ-032 After reset, both valid continuously with a=0x8000, b=0x8000 -> results alternate id 0,1,0,1; each sum 0x0000, carry 1.
REQ-033 rsp_ready held low 3 cycles in DONE -> rsp_* stable, req0_ready and req1_ready remain 0, busy=1.
REQ-034 rst pulsed at second CALC cycle -> all outputs 0 asynchronously, no response; next request 0x0F0F+0x00F1 -> 0x1000, carry 0.

Source files
------------

// File: rtl/add_arb_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the nibble-serial arbitrated adder: FSM state
// encoding, adder slice width and the default operand width.
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int NIB_W = 4;
    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_arb_seq_if.sv
// ---------------------------------------------------------------------------
// add_arb_seq_if
// Bundles both requester handshakes, the response handshake and the busy
// flag of add_arb_seq.
//   master : requester/consumer side (drives valids, operands, rsp_ready)
//   slave  : adder side (drives readies, response fields, busy)
// Parameter W : operand/sum width, multiple of 4 and at least 8.
// ---------------------------------------------------------------------------
interface add_arb_seq_if #(
    parameter int W = add_seq_pkg::W_DEF
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_carry;
    logic         rsp_id;

    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_sum, rsp_carry, rsp_id,
        output rsp_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_sum, rsp_carry, rsp_id,
        input  rsp_ready,
        output busy
    );

endinterface

// File: rtl/add_4_slice.sv
// ---------------------------------------------------------------------------
// add_4_slice
// Combinational 4-bit adder slice with carry in/out.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out of bit 3
// ---------------------------------------------------------------------------
module add_4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/add_arb_seq.sv
// ---------------------------------------------------------------------------
// add_arb_seq
// Two requesters share one 4-bit adder slice; the granted operand pair is
// summed nibble-serially (LSB nibble first) and returned with its carry
// and the owning requester id.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : add_arb_seq_if.slave (requester handshakes, response, busy)
// Parameter W : operand/sum width, multiple of 4 and at least 8; must match
// the W of the connected interface.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; granted requester sees ready
// ST_CALC | one nibble of the sum per clock through the shared slice
// ST_DONE | result presented on rsp_*, waiting for rsp_ready
// ---------------------------------------------------------------------------
module add_arb_seq
    import add_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    add_arb_seq_if.slave  bus
);

    localparam int NIBS  = W / NIB_W;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

    state_t           state;
    state_t           nxt_state;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_nib;

    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     work;
    logic             op_id;
    logic             carry_q;
    logic             last_grant;
    logic [CNT_W-1:0] nib_cnt;

    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    logic [W-1:0]     sum_q;
    logic             carry_out_q;
    logic             id_q;

    // last_grant = 1 means requester 1 won last, so requester 0 wins a tie.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    assign accept   = (state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
    assign last_nib = (nib_cnt == LAST_NIB);

    // Operands shift right one nibble per CALC cycle, so the slice always
    // sees the low nibble; no variable indexing is needed.
    add_4_slice u_nib (
        .a    (op_a[NIB_W-1:0]),
        .b    (op_b[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // FSM: next state
    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: if (accept)        nxt_state = ST_CALC;
            ST_CALC: if (last_nib)      nxt_state = ST_DONE;
            ST_DONE: if (bus.rsp_ready) nxt_state = ST_IDLE;
            default:                    nxt_state = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.req0_ready = (state == ST_IDLE) && grant0;
        bus.req1_ready = (state == ST_IDLE) && grant1;
        bus.rsp_valid  = (state == ST_DONE);
        bus.busy       = (state != ST_IDLE);
    end

    // Datapath. The sum is assembled in 'work' and only copied to the
    // visible result register on the last nibble, so rsp_sum keeps the
    // previous result throughout CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            work        <= '0;
            op_id       <= 1'b0;
            carry_q     <= 1'b0;
            nib_cnt     <= '0;
            last_grant  <= 1'b1;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            id_q        <= 1'b0;
        end else if (accept) begin
            op_a       <= grant1 ? bus.req1_a : bus.req0_a;
            op_b       <= grant1 ? bus.req1_b : bus.req0_b;
            op_id      <= grant1;
            last_grant <= grant1;
            carry_q    <= 1'b0;
            nib_cnt    <= '0;
        end else if (state == ST_CALC) begin
            op_a    <= op_a >> NIB_W;
            op_b    <= op_b >> NIB_W;
            work    <= {nib_sum, work[W-1:NIB_W]};
            carry_q <= nib_cout;
            nib_cnt <= last_nib ? '0 : nib_cnt + 1'b1;
            if (last_nib) begin
                sum_q       <= {nib_sum, work[W-1:NIB_W]};
                carry_out_q <= nib_cout;
                id_q        <= op_id;
            end
        end
    end

    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_out_q;
    assign bus.rsp_id    = id_q;

endmodule

// File: tb/tb_add_arb_seq.sv
module tb_add_arb_seq;

    localparam int W        = 16;
    localparam int NIBS     = W / 4;
    localparam int MAX_WAIT = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    add_arb_seq_if #(.W(W)) bus ();

    add_arb_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit m_last = 1'b1;   // reference model: id that won the most recent accept

    // Reference arbitration: lone valid wins, a tie goes to the other one.
    function automatic bit ref_pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return !last;
    endfunction

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle, then scrambles the operand
    // inputs and counts cycles until rsp_valid (-1 if it never comes).
    task automatic do_txn(input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          output logic rdy0, output logic rdy1, output int lat);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = 1'b0;
        #1;
        rdy0 = bus.req0_ready;
        rdy1 = bus.req1_ready;
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom);
        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom);
        lat = -1;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_sum !== '0) begin n_err++; $display("FAIL reset_rsp_sum got=%h exp=0", bus.rsp_sum); end
        n_vec++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL reset_rsp_carry got=%b exp=0", bus.rsp_carry); end
        n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id got=%b exp=0", bus.rsp_id); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tick();
        tick();
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_req0();
        logic r0, r1; int lat;
        do_txn(1'b1, 1'b0, 16'h1234, 16'h4321, 16'h0, 16'h0, r0, r1, lat);
        n_vec++; if (r0 !== 1'b1 || r1 !== 1'b0) begin n_err++; $display("FAIL req0_ready got=%b%b exp=10", r0, r1); end
        n_vec++; if (lat != NIBS) begin n_err++; $display("FAIL req0_latency got=%0d exp=%0d", lat, NIBS); end
        n_vec++; if (bus.rsp_sum !== 16'h5555) begin n_err++; $display("FAIL req0_sum got=%h exp=5555", bus.rsp_sum); end
        n_vec++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL req0_carry got=%b exp=0", bus.rsp_carry); end
        n_vec++; if (bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL req0_id got=%b exp=0", bus.rsp_id); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL req0_busy_done got=%b exp=1", bus.busy); end
        m_last = 1'b0;
        take();
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL req0_after_take got valid=%b busy=%b exp 0 0", bus.rsp_valid, bus.busy); end
        n_vec++; if (bus.rsp_sum !== 16'h5555) begin n_err++; $display("FAIL req0_sum_hold_idle got=%h exp=5555", bus.rsp_sum); end
    endtask

    task automatic test_req1_carry();
        logic r0, r1; int lat;
        do_txn(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'h0001, r0, r1, lat);
        n_vec++; if (r0 !== 1'b0 || r1 !== 1'b1) begin n_err++; $display("FAIL req1_ready got=%b%b exp=01", r0, r1); end
        n_vec++; if (lat != NIBS) begin n_err++; $display("FAIL req1_latency got=%0d exp=%0d", lat, NIBS); end
        n_vec++; if (bus.rsp_sum !== 16'h0000) begin n_err++; $display("FAIL req1_sum got=%h exp=0000", bus.rsp_sum); end
        n_vec++; if (bus.rsp_carry !== 1'b1) begin n_err++; $display("FAIL req1_carry got=%b exp=1", bus.rsp_carry); end
        n_vec++; if (bus.rsp_id !== 1'b1) begin n_err++; $display("FAIL req1_id got=%b exp=1", bus.rsp_id); end
        m_last = 1'b1;
        take();
    endtask

    task automatic test_backpressure();
        logic r0, r1; int lat; bit eid; logic [W:0] e;
        logic [W-1:0] a0, b0, a1, b1;
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        eid = ref_pick(1'b1, 1'b1, m_last);
        e   = eid ? ref_add(a1, b1) : ref_add(a0, b0);
        do_txn(1'b1, 1'b1, a0, b0, a1, b1, r0, r1, lat);
        n_vec++; if (r0 !== !eid || r1 !== eid) begin n_err++; $display("FAIL bp_grant got=%b%b exp_id=%0d", r0, r1, eid); end
        n_vec++; if (lat != NIBS) begin n_err++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NIBS); end
        for (int c = 0; c < 3; c++) begin
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
            #1;
            n_vec++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b%b exp=00", c, bus.req0_ready, bus.req1_ready); end
            n_vec++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_busy_valid cyc=%0d got=%b%b exp=11", c, bus.busy, bus.rsp_valid); end
            n_vec++; if ({bus.rsp_carry, bus.rsp_sum} !== e || bus.rsp_id !== eid) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b_%h id=%b exp=%h id=%b", c, bus.rsp_carry, bus.rsp_sum, bus.rsp_id, e, eid); end
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        m_last = eid;
        take();
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bp_after_take_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cnt, last_t; bit eid;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h8000; bus.req0_b = 16'h8000;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h8000; bus.req1_b = 16'h8000;
        bus.rsp_ready  = 1'b1;
        cnt = 0; last_t = -1;
        eid = ref_pick(1'b1, 1'b1, m_last);
        for (int t = 0; t < 80 && cnt < 4; t++) begin
            tick();
            if (bus.rsp_valid === 1'b1) begin
                n_vec++; if (bus.rsp_id !== eid) begin n_err++; $display("FAIL b2b_id n=%0d got=%b exp=%b", cnt, bus.rsp_id, eid); end
                n_vec++; if (bus.rsp_sum !== 16'h0000 || bus.rsp_carry !== 1'b1) begin n_err++; $display("FAIL b2b_result n=%0d got=%b_%h exp=1_0000", cnt, bus.rsp_carry, bus.rsp_sum); end
                if (cnt > 0) begin
                    n_vec++; if (t - last_t != NIBS + 2) begin n_err++; $display("FAIL b2b_interval n=%0d got=%0d exp=%0d", cnt, t - last_t, NIBS + 2); end
                end
                last_t = t;
                m_last = eid;
                eid = ref_pick(1'b1, 1'b1, m_last);
                cnt++;
                if (cnt == 4) begin
                    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                end
            end
        end
        n_vec++; if (cnt != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", cnt); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic r0, r1; int lat;
        do_txn(1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0, 16'h0, r0, r1, lat);
        n_vec++; if (lat != NIBS || bus.rsp_sum !== 16'h3333) begin n_err++; $display("FAIL rmid_pre got lat=%0d sum=%h exp lat=%0d sum=3333", lat, bus.rsp_sum, NIBS); end
        m_last = 1'b0;
        take();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h1111;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rmid_calc_busy got=%b exp=1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid_async_ctl got valid=%b busy=%b exp 0 0", bus.rsp_valid, bus.busy); end
        n_vec++; if (bus.rsp_sum !== '0 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL rmid_async_data got=%b_%h id=%b exp=0_0000 id=0", bus.rsp_carry, bus.rsp_sum, bus.rsp_id); end
        tick();
        rst = 1'b0;
        m_last = 1'b1;
        do_txn(1'b1, 1'b0, 16'h0F0F, 16'h00F1, 16'h0, 16'h0, r0, r1, lat);
        n_vec++; if (r0 !== 1'b1) begin n_err++; $display("FAIL rmid_first_edge_ready got=%b exp=1", r0); end
        n_vec++; if (lat != NIBS) begin n_err++; $display("FAIL rmid_latency got=%0d exp=%0d", lat, NIBS); end
        n_vec++; if (bus.rsp_sum !== 16'h1000 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 1'b0) begin n_err++; $display("FAIL rmid_result got=%b_%h id=%b exp=0_1000 id=0", bus.rsp_carry, bus.rsp_sum, bus.rsp_id); end
        m_last = 1'b0;
        take();
    endtask

    task automatic test_random();
        logic r0, r1; int lat; bit v0, v1, eid; logic [W:0] e;
        logic [W-1:0] a0, b0, a1, b1;
        int sel, gap, hold;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            sel = $urandom_range(1, 3);
            v0 = sel[0]; v1 = sel[1];
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            eid = ref_pick(v0, v1, m_last);
            e   = eid ? ref_add(a1, b1) : ref_add(a0, b0);
            do_txn(v0, v1, a0, b0, a1, b1, r0, r1, lat);
            n_vec++; if (r0 !== !eid || r1 !== eid) begin n_err++; $display("FAIL rnd_grant n=%0d v=%b%b got=%b%b exp_id=%0d", n, v1, v0, r1, r0, eid); end
            n_vec++; if (lat != NIBS) begin n_err++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, lat, NIBS); end
            n_vec++; if ({bus.rsp_carry, bus.rsp_sum} !== e || bus.rsp_id !== eid) begin n_err++; $display("FAIL rnd_result n=%0d got=%b_%h id=%b exp=%h id=%b", n, bus.rsp_carry, bus.rsp_sum, bus.rsp_id, e, eid); end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                n_vec++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_carry, bus.rsp_sum} !== e) begin n_err++; $display("FAIL rnd_hold n=%0d got valid=%b %b_%h exp valid=1 %h", n, bus.rsp_valid, bus.rsp_carry, bus.rsp_sum, e); end
            end
            m_last = eid;
            take();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_req0();
        test_req1_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
